lut_arbiter: RTL and testbench



---
 rtl/lut_arbiter_pkg.sv | 20 ++
 rtl/lut_arbiter_rr_picker.sv | 29 ++
 rtl/lut_arbiter.sv | 126 ++++++++++++
 tb/tb_lut_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/lut_arbiter_pkg.sv
// Shared types for the VPI lookup-table arbiter: table entry layout and the
// response-register record that tracks who owns the access in flight.
package lut_arbiter_pkg;

    localparam int NumTx      = 4;
    localparam int VpiWidth   = 12;
    localparam int OwnerWidth = 8;

    typedef struct packed {
        logic [NumTx-1:0]    fwd_mask;
        logic [VpiWidth-1:0] nni_vpi;
    } CellCfgType;

    typedef struct packed {
        logic                  is_cpu;
        logic                  is_read;
        logic [OwnerWidth-1:0] owner;
    } LutOwnerType;

endpackage

// File: rtl/lut_arbiter_rr_picker.sv
// Combinational round-robin picker: the first requester found searching from
// ptr+1 upward, wrapping modulo N, wins.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic found;

    // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!found && req[(int'(ptr) + i) % N]) begin
                found                      = 1'b1;
                idx                        = IW'((int'(ptr) + i) % N);
                gnt[(int'(ptr) + i) % N]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lut_arbiter.sv
// Arbiter for the shared single-port VPI lookup RAM: forwarding engines read,
// the CPU reads and writes, one access per cycle, response one cycle later.
module lut_arbiter
    import lut_arbiter_pkg::*;
#(
    parameter int NumReq = 4,
    parameter int Asize  = 8,
    parameter int DWidth = $bits(CellCfgType)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NumReq-1:0]       fwd_req,
    input  logic [NumReq*Asize-1:0] fwd_addr,
    output logic [NumReq-1:0]       fwd_gnt,
    output logic [NumReq-1:0]       fwd_rvalid,
    output logic [DWidth-1:0]       fwd_rdata,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [Asize-1:0]        cpu_addr,
    input  logic [DWidth-1:0]       cpu_wdata,
    output logic                    cpu_gnt,
    output logic                    cpu_ack,
    output logic [DWidth-1:0]       cpu_rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [Asize-1:0]        mem_addr,
    output logic [DWidth-1:0]       mem_wdata,
    input  logic [DWidth-1:0]       mem_rdata
);

    localparam int IdxW = $clog2(NumReq);

    logic [IdxW-1:0]   rr_ptr;
    logic [IdxW-1:0]   pick_idx;
    logic [NumReq-1:0] pick_gnt;
    logic              cpu_last;
    logic              resp_valid;
    LutOwnerType       resp;
    logic [DWidth-1:0] fwd_rdata_q;
    logic [DWidth-1:0] cpu_rdata_q;
    logic              fwd_any;
    logic              cpu_wins;
    logic              fwd_wins;

    rr_picker #(.N(NumReq)) u_picker (
        .req (fwd_req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // The CPU yields to pending forwarding traffic right after its own grant.
    always_comb begin
        fwd_any  = |fwd_req;
        cpu_wins = cpu_req && !(cpu_last && fwd_any);
        fwd_wins = fwd_any && !cpu_wins;
    end

    always_comb begin
        cpu_gnt   = 1'b0;
        fwd_gnt   = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = fwd_addr[int'(pick_idx)*Asize +: Asize];
        mem_wdata = cpu_wdata;
        if (rst) begin
            if (cpu_wins) begin
                cpu_gnt  = 1'b1;
                mem_en   = 1'b1;
                mem_we   = cpu_we;
                mem_addr = cpu_addr;
            end else if (fwd_wins) begin
                fwd_gnt = pick_gnt;
                mem_en  = 1'b1;
            end
        end
    end

    // Strobes come straight from the response register; data is shown live
    // from the RAM on the strobe cycle and held in the _q copies afterwards.
    always_comb begin
        fwd_rvalid = '0;
        cpu_ack    = 1'b0;
        fwd_rdata  = fwd_rdata_q;
        cpu_rdata  = cpu_rdata_q;
        if (rst && resp_valid) begin
            if (resp.is_cpu) begin
                cpu_ack = 1'b1;
                if (resp.is_read) begin
                    cpu_rdata = mem_rdata;
                end
            end else begin
                fwd_rvalid[resp.owner[IdxW-1:0]] = 1'b1;
                fwd_rdata                        = mem_rdata;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr      <= IdxW'(NumReq - 1);
            cpu_last    <= 1'b0;
            resp_valid  <= 1'b0;
            resp        <= '0;
            fwd_rdata_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            cpu_last     <= cpu_gnt;
            resp_valid   <= mem_en;
            resp.is_cpu  <= cpu_gnt;
            resp.is_read <= !mem_we;
            resp.owner   <= OwnerWidth'(pick_idx);
            if (|fwd_gnt) begin
                rr_ptr <= pick_idx;
            end
            if (resp_valid && !resp.is_cpu) begin
                fwd_rdata_q <= mem_rdata;
            end
            if (resp_valid && resp.is_cpu && resp.is_read) begin
                cpu_rdata_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_lut_arbiter.sv
// Directed bench for lut_arbiter with a behavioural single-port RAM and a
// table of hand-computed grant / response expectations.
module tb_lut_arbiter;

    localparam int NumReq = 4;
    localparam int Asize  = 8;
    localparam int DWidth = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NumReq-1:0]       fwd_req;
    logic [NumReq*Asize-1:0] fwd_addr;
    logic [NumReq-1:0]       fwd_gnt;
    logic [NumReq-1:0]       fwd_rvalid;
    logic [DWidth-1:0]       fwd_rdata;
    logic                    cpu_req;
    logic                    cpu_we;
    logic [Asize-1:0]        cpu_addr;
    logic [DWidth-1:0]       cpu_wdata;
    logic                    cpu_gnt;
    logic                    cpu_ack;
    logic [DWidth-1:0]       cpu_rdata;
    logic                    mem_en;
    logic                    mem_we;
    logic [Asize-1:0]        mem_addr;
    logic [DWidth-1:0]       mem_wdata;
    logic [DWidth-1:0]       mem_rdata;

    logic [DWidth-1:0] ram [256];

    int n_tests = 0;
    int n_fail  = 0;

    lut_arbiter #(.NumReq(NumReq), .Asize(Asize), .DWidth(DWidth)) dut (
        .clk        (clk),
        .rst        (rst),
        .fwd_req    (fwd_req),
        .fwd_addr   (fwd_addr),
        .fwd_gnt    (fwd_gnt),
        .fwd_rvalid (fwd_rvalid),
        .fwd_rdata  (fwd_rdata),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM, preloaded with entry = 0x1000 + address.
    initial begin
        mem_rdata = '0;
        for (int a = 0; a < 256; a++) ram[a] = 16'h1000 + 16'(a);
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) ram[mem_addr] <= mem_wdata;
                else        mem_rdata     <= ram[mem_addr];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  fwd_req;
        logic [31:0] fwd_addr;
        logic        cpu_req;
        logic        cpu_we;
        logic [7:0]  cpu_addr;
        logic [15:0] cpu_wdata;
        logic [3:0]  exp_fwd_gnt;
        logic        exp_cpu_gnt;
        logic        exp_we;
        logic [7:0]  exp_addr;
        logic [15:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(logic [3:0] fr, logic [31:0] fa, logic cr, logic cw,
                                logic [7:0] ca, logic [15:0] cd, logic [3:0] eg,
                                logic ec, logic ew, logic [7:0] ea, logic [15:0] ed);
        vec_t v;
        v.fwd_req = fr; v.fwd_addr = fa; v.cpu_req = cr; v.cpu_we = cw;
        v.cpu_addr = ca; v.cpu_wdata = cd; v.exp_fwd_gnt = eg; v.exp_cpu_gnt = ec;
        v.exp_we = ew; v.exp_addr = ea; v.exp_rdata = ed;
        return v;
    endfunction

    localparam logic [31:0] AddrA = 32'h13121110;
    localparam logic [31:0] AddrB = 32'h13124210;

    vec_t vecs [19];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // first grant after reset goes to CPU
        vecs[0]  = mk(4'b1111, AddrA, 1, 0, 8'h05, 16'h0,    4'b0000, 1, 0, 8'h05, 16'h1005);
        // round robin 0,1,2,3,0
        vecs[1]  = mk(4'b1111, AddrA, 0, 0, 8'h00, 16'h0,    4'b0001, 0, 0, 8'h10, 16'h1010);
        vecs[2]  = mk(4'b1111, AddrA, 0, 0, 8'h00, 16'h0,    4'b0010, 0, 0, 8'h11, 16'h1011);
        vecs[3]  = mk(4'b1111, AddrA, 0, 0, 8'h00, 16'h0,    4'b0100, 0, 0, 8'h12, 16'h1012);
        vecs[4]  = mk(4'b1111, AddrA, 0, 0, 8'h00, 16'h0,    4'b1000, 0, 0, 8'h13, 16'h1013);
        vecs[5]  = mk(4'b1111, AddrA, 0, 0, 8'h00, 16'h0,    4'b0001, 0, 0, 8'h10, 16'h1010);
        // fairness: CPU and engine 2 alternate
        vecs[6]  = mk(4'b0100, AddrA, 1, 0, 8'h20, 16'h0,    4'b0000, 1, 0, 8'h20, 16'h1020);
        vecs[7]  = mk(4'b0100, AddrA, 1, 0, 8'h20, 16'h0,    4'b0100, 0, 0, 8'h12, 16'h1012);
        vecs[8]  = mk(4'b0100, AddrA, 1, 0, 8'h20, 16'h0,    4'b0000, 1, 0, 8'h20, 16'h1020);
        vecs[9]  = mk(4'b0100, AddrA, 1, 0, 8'h20, 16'h0,    4'b0100, 0, 0, 8'h12, 16'h1012);
        vecs[10] = mk(4'b0100, AddrA, 1, 0, 8'h20, 16'h0,    4'b0000, 1, 0, 8'h20, 16'h1020);
        vecs[11] = mk(4'b0100, AddrA, 1, 0, 8'h20, 16'h0,    4'b0100, 0, 0, 8'h12, 16'h1012);
        // RAW: write 0x42 then engine 1 reads it; cpu_rdata holds across the write ack
        vecs[12] = mk(4'b0000, AddrA, 1, 1, 8'h42, 16'hA5C3, 4'b0000, 1, 1, 8'h42, 16'h1020);
        vecs[13] = mk(4'b0010, AddrB, 0, 0, 8'h00, 16'h0,    4'b0010, 0, 0, 8'h42, 16'hA5C3);
        // withdraw: engine 1 drops while CPU is granted; rr_ptr stays at 1
        vecs[14] = mk(4'b0010, AddrA, 1, 0, 8'h07, 16'h0,    4'b0000, 1, 0, 8'h07, 16'h1007);
        vecs[15] = mk(4'b0000, AddrA, 1, 0, 8'h08, 16'h0,    4'b0000, 1, 0, 8'h08, 16'h1008);
        vecs[16] = mk(4'b1001, AddrA, 0, 0, 8'h00, 16'h0,    4'b1000, 0, 0, 8'h13, 16'h1013);
        // wrap from rr_ptr=3 to engine 0, then idle
        vecs[17] = mk(4'b1111, AddrA, 0, 0, 8'h00, 16'h0,    4'b0001, 0, 0, 8'h10, 16'h1010);
        vecs[18] = mk(4'b0000, AddrA, 0, 0, 8'h00, 16'h0,    4'b0000, 0, 0, 8'h00, 16'h0000);

        rst = 1'b0; fwd_req = 4'b1111; fwd_addr = AddrA;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h01; cpu_wdata = 16'hFFFF;

        // reset held with every request asserted
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_fwd_gnt", 32'(fwd_gnt), 32'h0);
            check("rst_cpu_gnt", 32'(cpu_gnt), 32'h0);
            check("rst_mem_en",  32'(mem_en),  32'h0);
            check("rst_mem_we",  32'(mem_we),  32'h0);
            check("rst_rvalid",  32'(fwd_rvalid), 32'h0);
            check("rst_ack",     32'(cpu_ack), 32'h0);
        end
        check("rst_fwd_rdata", 32'(fwd_rdata), 32'h0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);

        rst = 1'b1;
        for (int i = 0; i < 19; i++) begin
            fwd_req   = vecs[i].fwd_req;
            fwd_addr  = vecs[i].fwd_addr;
            cpu_req   = vecs[i].cpu_req;
            cpu_we    = vecs[i].cpu_we;
            cpu_addr  = vecs[i].cpu_addr;
            cpu_wdata = vecs[i].cpu_wdata;
            #1;
            check($sformatf("v%0d_fwd_gnt", i), 32'(fwd_gnt), 32'(vecs[i].exp_fwd_gnt));
            check($sformatf("v%0d_cpu_gnt", i), 32'(cpu_gnt), 32'(vecs[i].exp_cpu_gnt));
            check($sformatf("v%0d_mem_en", i), 32'(mem_en),
                  32'(vecs[i].exp_cpu_gnt || (vecs[i].exp_fwd_gnt != 4'b0)));
            check($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].exp_we));
            if (vecs[i].exp_cpu_gnt || (vecs[i].exp_fwd_gnt != 4'b0))
                check($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].exp_addr));
            tick();
            check($sformatf("v%0d_rvalid", i), 32'(fwd_rvalid), 32'(vecs[i].exp_fwd_gnt));
            check($sformatf("v%0d_ack", i), 32'(cpu_ack), 32'(vecs[i].exp_cpu_gnt));
            if (vecs[i].exp_fwd_gnt != 4'b0)
                check($sformatf("v%0d_fwd_rdata", i), 32'(fwd_rdata), 32'(vecs[i].exp_rdata));
            if (vecs[i].exp_cpu_gnt)
                check($sformatf("v%0d_cpu_rdata", i), 32'(cpu_rdata), 32'(vecs[i].exp_rdata));
        end

        // reset mid-read: engine 3 granted, reset asserted the next cycle
        fwd_req = 4'b1000; fwd_addr = AddrA; cpu_req = 1'b0; cpu_we = 1'b0;
        #1;
        check("midrst_gnt", 32'(fwd_gnt), 32'h8);
        tick();
        rst = 1'b0;
        #1;
        check("midrst_rvalid_t1", 32'(fwd_rvalid), 32'h0);
        check("midrst_gnt_low",   32'(fwd_gnt),    32'h0);
        tick();
        check("midrst_rvalid_t2", 32'(fwd_rvalid), 32'h0);
        rst = 1'b1; fwd_req = 4'b1111;
        #1;
        check("midrst_restart_gnt", 32'(fwd_gnt), 32'h1);
        tick();
        check("midrst_restart_rvalid", 32'(fwd_rvalid), 32'h1);
        check("midrst_restart_rdata",  32'(fwd_rdata),  32'h1010);

        // idle reset after rr_ptr moved to 0 must bring engine 0 back first
        fwd_req = 4'b0000;
        rst = 1'b0;
        tick();
        check("rst2_ack", 32'(cpu_ack), 32'h0);
        rst = 1'b1; fwd_req = 4'b1111;
        #1;
        check("rst2_rr_restored", 32'(fwd_gnt), 32'h1);
        tick();
        fwd_req = 4'b0000;
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
